divider: RTL and testbench
==========================

Name: divider

Overview:
- Sequential radix-2 restoring integer divider. It is the inverse-operation companion to the ALU multiplier.
- Serves RISC-V M-extension DIV/DIVU/REM/REMU from one operand pair.
- Produces quotient and remainder together.
- Uses the same start/busy/valid handshake as the multiplier, so the ALU sequencer drives both units identically.

Parameters:
- XLEN, 32, operand, quotient and remainder width.
- CNT_W, 6, iteration counter width; must hold the value XLEN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- rs1  input  XLEN  dividend.
- rs2  input  XLEN  divisor.
- div_signed  input  1  1 = two's-complement divide (DIV/REM); 0 = unsigned (DIVU/REMU).
- start  input  1  request; accepted only on a rising edge where busy=0.
- quotient  output  XLEN  registered quotient.
- remainder  output  XLEN  registered remainder.
- valid  output  1  one-cycle pulse: results updated this cycle.
- busy  output  1  operation in progress; start is ignored while high.

Behaviour:
- Reset (async, any time, including mid-operation): quotient=0, remainder=0, valid=0, busy=0, FSM=IDLE, counter=0, internal regs=0. Any in-flight operation is discarded and produces no valid.
- FSM states: IDLE, DIVIDE, FINISH.
- Accept edge, IDLE with start=1:
  - Latch rs1, rs2 and div_signed.
  - Later input changes have no effect on the operation.
  - Compute sign flags: neg_q = div_signed & (rs1[31] ^ rs2[31]); neg_r = div_signed & rs1[31].
  - Load internal dividend with |rs1| when signed, else rs1.
  - Load internal divisor with |rs2| when signed, else rs2.
  - Load partial remainder=0, counter=0.
  - Set busy=1 and valid=0. Go to DIVIDE.
- DIVIDE, one iteration per cycle, XLEN cycles:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor using an XLEN+1-bit subtract, so no carry-out is lost.
  - If the result is non-negative: keep the difference and shift 1 into the quotient LSB.
  - Otherwise: restore the remainder and shift in 0.
  - counter increments. After the iteration with counter==XLEN-1, go to FINISH.
- FINISH, one cycle:
  - quotient = neg_q ? -q : q; remainder = neg_r ? -r : r.
  - Apply the special cases below, which override these values.
  - valid=1 for this single cycle, busy=0, return to IDLE.
- Latency: the accept edge is E0; the results register and valid rises on edge E(XLEN+1), i.e. E33 for the default. Latency is fixed for every operand pair, including the special cases.
- valid returns to 0 on the following edge. quotient and remainder hold their values until the next FINISH or reset.
- Special cases (RISC-V semantics, evaluated on the latched operands):
  - Divisor==0: quotient = all ones, remainder = dividend (raw rs1), for both signed and unsigned.
  - Signed overflow, rs1 = 0x80000000 and rs2 = 0xFFFFFFFF with div_signed=1: quotient=0x80000000, remainder=0.
- start=1 while busy=1: ignored; there is no queuing.
- start held high continuously: a new operation is accepted on the edge after FINISH, since busy=0 then. Back-to-back throughput is therefore one result per XLEN+2 cycles.
- Simultaneous rst and start: reset wins.
- Width rules:
  - Magnitude of 0x80000000 is 0x80000000 when treated as unsigned; the datapath is unsigned XLEN bits.
  - Negation is two's-complement, modulo 2^XLEN.
  - Remainder sign always follows the dividend; remainder magnitude is always less than the divisor magnitude, for divisor≠0.

Test Plan:
1. Unsigned 100 / 7 (div_signed=0), single start pulse:
   - busy is high from E1 to E32.
   - valid pulses at E33 only, with quotient=14, remainder=2.
   - valid=0 at E34 while the outputs hold.
2. Signed cases:
   - rs1=0xFFFFFFF9 (-7), rs2=2 → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
   - rs1=7, rs2=0xFFFFFFFE → quotient=0xFFFFFFFD, remainder=1.
   - Unsigned 0xFFFFFFFF / 1 → quotient=0xFFFFFFFF, remainder=0.
3. Divide by zero with rs1=0x12345678, rs2=0, in both modes:
   - quotient=0xFFFFFFFF, remainder=0x12345678.
   - Signed rs1=0x80000000, rs2=0 → quotient=0xFFFFFFFF, remainder=0x80000000.
   - Latency is still 33 cycles.
4. Overflow, rs1=0x80000000, rs2=0xFFFFFFFF:
   - Signed → quotient=0x80000000, remainder=0.
   - Unsigned → quotient=0, remainder=0x80000000.
5. Handshake and robustness:
   - Pulse start again at E10 with different operands, and change rs1/rs2 mid-operation: the first result is unchanged, and no second operation starts.
   - Hold start high for 80 cycles: valid pulses at E33 and E67.
6. Reset mid-operation:
   - Assert rst asynchronously at E15 (not aligned to an edge): all outputs go to 0 immediately, and no valid appears afterwards.
   - After release, 100 / 7 completes correctly with the full 33-cycle latency.

Source files
------------

// File: rtl/divider.sv
// divider: sequential radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
//
// Each operation produces the quotient and the remainder together, and always
// takes XLEN+1 cycles from the accept edge to the valid pulse. The start/busy/
// valid handshake matches the multiplier, so one sequencer can drive both.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; discards any in-flight operation
//   rs1        dividend
//   rs2        divisor
//   div_signed 1 = two's-complement divide (DIV/REM), 0 = unsigned (DIVU/REMU)
//   start      request; accepted only on an edge where busy is low
//   quotient   registered quotient, held until the next result or reset
//   remainder  registered remainder, held until the next result or reset
//   valid      one-cycle pulse in the cycle the results are updated
//   busy       high while an operation is in progress; start is ignored then
module divider #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            div_signed,
    input  logic            start,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            valid,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    state_t r_state;
    state_t w_next;

    logic [CNT_W-1:0] r_cnt;
    // r_dvd holds the dividend bits still to be consumed in its upper part and
    // the quotient bits produced so far in its lower part.
    logic [XLEN-1:0]  r_dvd;
    logic [XLEN-1:0]  r_dvs;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_rs1;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div0;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic [XLEN-1:0]  w_abs1;
    logic [XLEN-1:0]  w_abs2;
    logic [XLEN:0]    w_trial;
    logic [XLEN-1:0]  w_q_fin;
    logic [XLEN-1:0]  w_r_fin;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_cnt == CNT_W'(XLEN - 1));

    // Magnitudes as unsigned XLEN-bit values; the most negative value maps to
    // itself, which is its correct unsigned magnitude.
    assign w_abs1 = (div_signed && rs1[XLEN-1]) ? -rs1 : rs1;
    assign w_abs2 = (div_signed && rs2[XLEN-1]) ? -rs2 : rs2;

    // One extra bit so the borrow of the trial subtract is never lost.
    assign w_trial = {r_rem, r_dvd[XLEN-1]} - {1'b0, r_dvs};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = start ? S_DIVIDE : S_IDLE;
            S_DIVIDE: w_next = w_last ? S_FINISH : S_DIVIDE;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output logic: busy flag and the sign-corrected, special-cased results.
    always_comb begin
        busy    = (r_state != S_IDLE);
        w_q_fin = r_neg_q ? -r_dvd : r_dvd;
        w_r_fin = r_neg_r ? -r_rem : r_rem;
        if (r_div0) begin
            w_q_fin = ALL_ONES;
            w_r_fin = r_rs1;
        end else if (r_ovf) begin
            w_q_fin = MOST_NEG;
            w_r_fin = '0;
        end
    end

    // Datapath: operand capture on accept, one restoring step per DIVIDE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_rs1   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_dvd   <= w_abs1;
            r_dvs   <= w_abs2;
            r_rem   <= '0;
            r_rs1   <= rs1;
            r_neg_q <= div_signed & (rs1[XLEN-1] ^ rs2[XLEN-1]);
            r_neg_r <= div_signed & rs1[XLEN-1];
            r_div0  <= (rs2 == '0);
            r_ovf   <= div_signed && (rs1 == MOST_NEG) && (rs2 == ALL_ONES);
        end else if (r_state == S_DIVIDE) begin
            r_cnt <= r_cnt + 1'b1;
            if (!w_trial[XLEN]) begin
                r_rem <= w_trial[XLEN-1:0];
                r_dvd <= {r_dvd[XLEN-2:0], 1'b1};
            end else begin
                r_rem <= {r_rem[XLEN-2:0], r_dvd[XLEN-1]};
                r_dvd <= {r_dvd[XLEN-2:0], 1'b0};
            end
        end
    end

    // Result registers and the valid pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient  <= '0;
            remainder <= '0;
            valid     <= 1'b0;
        end else begin
            valid <= (r_state == S_FINISH);
            if (r_state == S_FINISH) begin
                quotient  <= w_q_fin;
                remainder <= w_r_fin;
            end
        end
    end

endmodule

// File: tb/tb_divider.sv
// tb_divider: directed self-checking bench for the restoring divider.
module tb_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        div_signed = 1'b0;
    logic        start = 1'b0;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        valid;
    logic        busy;

    int total = 0;
    int bad   = 0;

    divider dut (
        .clk        (clk),
        .rst        (rst),
        .rs1        (rs1),
        .rs2        (rs2),
        .div_signed (div_signed),
        .start      (start),
        .quotient   (quotient),
        .remainder  (remainder),
        .valid      (valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation with a single start pulse, then follow it edge by
    // edge: busy through E32, valid only at E33, outputs held at E34.
    // With disturb set, start is pulsed again at E10 with other operands and
    // the inputs keep changing; the running operation must not notice.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] eq, input logic [31:0] er,
                          input bit disturb);
        @(negedge clk);
        rs1 = a;
        rs2 = b;
        div_signed = s;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk);
            #1;
            if (disturb && k == 9) begin
                start = 1'b1;
                rs1 = 32'h0000_0009;
                rs2 = 32'h0000_0003;
                div_signed = ~s;
            end
            if (disturb && k == 10) begin
                start = 1'b0;
                rs1 = 32'hDEAD_BEEF;
                rs2 = 32'h0000_0000;
            end
            if (k <= 32)
                chk({tag, " busy/valid during op"}, {30'd0, busy, valid}, 32'd2);
            else if (k == 33) begin
                chk({tag, " busy/valid at E33"}, {30'd0, busy, valid}, 32'd1);
                chk({tag, " quotient"}, quotient, eq);
                chk({tag, " remainder"}, remainder, er);
            end else begin
                chk({tag, " busy/valid at E34"}, {30'd0, busy, valid}, 32'd0);
                chk({tag, " quotient hold"}, quotient, eq);
                chk({tag, " remainder hold"}, remainder, er);
            end
        end
        if (disturb)
            for (int k = 0; k < 5; k++) begin
                @(posedge clk);
                #1 chk({tag, " no second op"}, {30'd0, busy, valid}, 32'd0);
            end
    endtask

    initial begin
        #1;
        chk("reset quotient", quotient, 32'h0);
        chk("reset remainder", remainder, 32'h0);
        chk("reset busy/valid", {30'd0, busy, valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("udiv 100/7",        32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0);
        run_op("sdiv -7/2",         32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        run_op("sdiv 7/-2",         32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1,        1'b0);
        run_op("sdiv -100/-7",      32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14,       32'hFFFFFFFE, 1'b0);
        run_op("udiv max/1",        32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'd0,        1'b0);
        run_op("udiv by zero",      32'h12345678, 32'd0,        1'b0, 32'hFFFFFFFF, 32'h12345678, 1'b0);
        run_op("sdiv by zero",      32'h12345678, 32'd0,        1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b0);
        run_op("sdiv minneg by 0",  32'h80000000, 32'd0,        1'b1, 32'hFFFFFFFF, 32'h80000000, 1'b0);
        run_op("sdiv overflow",     32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0);
        run_op("udiv minneg/max",   32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000, 1'b0);
        run_op("udiv 100/7 disturb", 32'd100,     32'd7,        1'b0, 32'd14,       32'd2,        1'b1);

        // start held high: accepted at E0, then again at E34 (first idle edge).
        @(negedge clk);
        rs1 = 32'd100;
        rs2 = 32'd7;
        div_signed = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk);
            #1 chk($sformatf("held start valid E%0d", k), {31'd0, valid}, {31'd0, (k == 33 || k == 67)});
            if (k == 33 || k == 67)
                chk($sformatf("held start quotient E%0d", k), quotient, 32'd14);
        end
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40; k++) @(posedge clk);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        rs1 = 32'd100;
        rs2 = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k < 15; k++) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async rst quotient", quotient, 32'h0);
        chk("async rst remainder", remainder, 32'h0);
        chk("async rst busy/valid", {30'd0, busy, valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1 chk($sformatf("after rst idle %0d", k), {30'd0, busy, valid}, 32'd0);
        end
        run_op("udiv 100/7 after rst", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
